// File: rtl/framebuffer_ctrl.sv
// Double-buffered 3-bit framebuffer: the renderer writes the back bank, the
// VGA path reads the front bank, and the banks swap at the first frame_start
// after render_done. The back bank is cleared before each render grant.
module framebuffer_ctrl #(
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter logic [2:0]  CLEAR_COLOR = 3'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [17:0] coords_in,
  input  logic [2:0]  color_in,
  input  logic        we_in,
  input  logic        render_done,
  output logic        render_ack,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [2:0]  pixel_color,
  output logic        clearing,
  output logic [7:0]  frame_count
);

  localparam int unsigned NPIX = H_RES * V_RES;
  localparam int unsigned AW   = $clog2(NPIX);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACK,
    S_RENDER,
    S_WAIT_VS
  } state_t;

  state_t         state, state_next;
  logic [AW-1:0]  clr_addr;
  logic           clr_last;
  logic           swap;
  logic           front_sel;
  logic           front_valid;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [2:0]     wr_data;
  logic [8:0]     wx, wy;
  logic           wr_in_range;

  logic [AW-1:0]  rd_addr;
  logic           rd_sel;
  logic           rd_ok;
  logic           draw_in_range;

  logic [2:0]     bank0 [NPIX];
  logic [2:0]     bank1 [NPIX];

  // Linear pixel address y*H_RES + x; a constant multiply reduces to shifts/adds.
  function automatic logic [AW-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return AW'(32'(y) * H_RES + 32'(x));
  endfunction

  assign wx            = coords_in[8:0];
  assign wy            = coords_in[17:9];
  assign wr_in_range   = (32'(wx) < H_RES) && (32'(wy) < V_RES);
  assign draw_in_range = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);
  assign clr_last      = (clr_addr == AW'(NPIX - 1));
  assign swap          = (state == S_WAIT_VS) && frame_start;

  // Next-state logic and back-bank write port selection.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = CLEAR_COLOR;
    unique case (state)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        if (clr_last) state_next = S_ACK;
      end
      S_ACK: state_next = S_RENDER;
      S_RENDER: begin
        wr_en   = we_in && wr_in_range;
        wr_addr = pix_addr({1'b0, wx}, {1'b0, wy});
        wr_data = color_in;
        if (render_done) state_next = S_WAIT_VS;
      end
      S_WAIT_VS: if (frame_start) state_next = S_CLEAR;
      default: state_next = S_CLEAR;
    endcase
  end

  // State register, clear address, bank swap and registered status outputs.
  // clearing/render_ack follow the state by one cycle so both reset to 0
  // while the FSM itself resets into CLEAR.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_CLEAR;
      clr_addr    <= '0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      frame_count <= '0;
      clearing    <= 1'b0;
      render_ack  <= 1'b0;
    end else begin
      state      <= state_next;
      clearing   <= (state == S_CLEAR);
      render_ack <= (state == S_ACK);
      if (state == S_CLEAR) clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
      if (swap) begin
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Back-bank write port; the back bank is always the one not selected as front.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (front_sel) bank0[wr_addr] <= wr_data;
      else           bank1[wr_addr] <= wr_data;
    end
  end

  // Read stage 0: register coordinates with the bank select so a swap cannot tear an in-flight pixel.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_addr <= '0;
      rd_sel  <= 1'b0;
      rd_ok   <= 1'b0;
    end else begin
      rd_addr <= draw_in_range ? pix_addr(DrawX, DrawY) : '0;
      rd_sel  <= front_sel;
      rd_ok   <= draw_in_range && front_valid;
    end
  end

  // Read stage 1: front-bank RAM read, forced to 0 for invalid coordinates or no front frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pixel_color <= '0;
    end else if (!rd_ok) begin
      pixel_color <= '0;
    end else begin
      pixel_color <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Randomized bench for framebuffer_ctrl with a small frame size, checked every
// cycle against a bank-level behavioural model plus a few literal expectations.
`timescale 1ns/1ps
module tb_framebuffer_ctrl;

  localparam int unsigned H    = 12;
  localparam int unsigned V    = 8;
  localparam int unsigned NPIX = H * V;
  localparam logic [2:0]  CC   = 3'd6;

  localparam int MD_CLEAR  = 0;
  localparam int MD_GRANT  = 1;
  localparam int MD_RENDER = 2;
  localparam int MD_WAIT   = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [17:0] coords_in = '0;
  logic [2:0]  color_in = '0;
  logic        we_in = 1'b0;
  logic        render_done = 1'b0;
  logic        render_ack;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [2:0]  pixel_color;
  logic        clearing;
  logic [7:0]  frame_count;

  framebuffer_ctrl #(.H_RES(H), .V_RES(V), .CLEAR_COLOR(CC)) dut (
    .Clk(Clk), .Reset(Reset), .coords_in(coords_in), .color_in(color_in),
    .we_in(we_in), .render_done(render_done), .render_ack(render_ack),
    .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_color(pixel_color), .clearing(clearing), .frame_count(frame_count)
  );

  always #5 Clk = ~Clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  bit          rand_draw = 1'b1;

  // Behavioural model: two banks indexed by model front select.
  logic [2:0] mem [2][NPIX];
  int         m_mode = MD_CLEAR;
  int         m_left = NPIX;
  int         m_sel = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_count = '0;
  logic [2:0] m_stage = '0;
  logic [2:0] e_pix = '0;
  bit         e_clear = 1'b0;
  bit         e_ack = 1'b0;
  int         dx, dy, wx, wy;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  endtask

  task automatic model_reset();
    m_mode  = MD_CLEAR;
    m_left  = NPIX;
    m_sel   = 0;
    m_valid = 1'b0;
    m_count = '0;
    m_stage = '0;
    e_pix   = '0;
    e_clear = 1'b0;
    e_ack   = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[1][i] = CC;
  endtask

  // Model step at every clock edge (or asynchronously on reset).
  initial forever begin
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      model_reset();
    end else begin
      dx = int'(DrawX);
      dy = int'(DrawY);
      wx = int'(coords_in[8:0]);
      wy = int'(coords_in[17:9]);
      e_pix = m_stage;
      m_stage = (m_valid && dx < H && dy < V) ? mem[m_sel][dy * H + dx] : 3'd0;
      e_clear = (m_mode == MD_CLEAR);
      e_ack   = (m_mode == MD_GRANT);
      case (m_mode)
        MD_CLEAR: begin
          m_left--;
          if (m_left == 0) m_mode = MD_GRANT;
        end
        MD_GRANT: m_mode = MD_RENDER;
        MD_RENDER: begin
          if (we_in && wx < H && wy < V) mem[1 - m_sel][wy * H + wx] = color_in;
          if (render_done) m_mode = MD_WAIT;
        end
        default: begin
          if (frame_start) begin
            m_sel   = 1 - m_sel;
            m_valid = 1'b1;
            m_count = m_count + 8'd1;
            for (int i = 0; i < NPIX; i++) mem[1 - m_sel][i] = CC;
            m_left  = NPIX;
            m_mode  = MD_CLEAR;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge Clk);
    check("pixel_color", 8'(pixel_color), 8'(e_pix));
    check("clearing", 8'(clearing), 8'(e_clear));
    check("render_ack", 8'(render_ack), 8'(e_ack));
    check("frame_count", frame_count, m_count);
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  task automatic tick();
    @(negedge Clk);
    we_in       = 1'b0;
    render_done = 1'b0;
    frame_start = 1'b0;
    if (rand_draw) begin
      DrawX = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H + 1));
      DrawY = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, V + 1));
    end
  endtask

  task automatic wait_ack(input bit strays, output int cycles, output int clr_cycles);
    cycles = 0;
    clr_cycles = 0;
    do begin
      tick();
      cycles++;
      if (clearing) clr_cycles++;
      if (strays && !render_ack) begin
        frame_start = ($urandom_range(0, 15) == 0);
        render_done = ($urandom_range(0, 15) == 0);
      end
    end while (!render_ack && cycles < int'(NPIX) + 50);
    if (!render_ack) begin
      vectors++;
      errors++;
      $display("FAIL ack_timeout: got no render_ack within %0d cycles", cycles);
      finish_run();
    end
  endtask

  task automatic set_write(input int x, input int y, input logic [2:0] c);
    we_in     = 1'b1;
    coords_in = {9'(y), 9'(x)};
    color_in  = c;
  endtask

  task automatic read_px(input string name, input int x, input int y, input logic [2:0] exp);
    tick();
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    tick();
    check(name, 8'(pixel_color), 8'(exp));
  endtask

  task automatic render_frame(input int nwrites, input bit fs_with_done);
    for (int i = 0; i < nwrites; i++) begin
      tick();
      we_in     = ($urandom_range(0, 3) != 0);
      coords_in = {9'($urandom_range(0, V + 1)),
                   ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, H + 1))};
      color_in  = 3'($urandom_range(0, 7));
    end
    tick();
    render_done = 1'b1;
    frame_start = fs_with_done;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      tick();
      we_in     = 1'b1;
      coords_in = {9'($urandom_range(0, V - 1)), 9'($urandom_range(0, H - 1))};
      color_in  = 3'($urandom_range(0, 7));
    end
    tick();
    frame_start = 1'b1;
  endtask

  int cyc, clr;

  initial begin
    #1 Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;

    // Reset-time clear, then a single-cycle grant.
    wait_ack(1'b0, cyc, clr);
    check("first_ack_latency", 8'(cyc), 8'(NPIX + 1));
    check("first_clear_len", 8'(clr), 8'(NPIX));
    check("count_after_reset", frame_count, 8'd0);

    // First frame: corner pixels, out-of-range writes, write on render_done, coincident frame_start.
    rand_draw = 1'b0;
    set_write(5, 7, 3'd5);
    tick(); set_write(H - 1, V - 1, 3'd2);
    tick(); set_write(H, 0, 3'd1);
    tick(); set_write(0, V, 3'd1);
    tick(); set_write(0, 0, 3'd4); render_done = 1'b1; frame_start = 1'b1;
    tick(); check("ack_single_cycle", 8'(render_ack), 8'd0);
    tick(); tick();
    check("no_swap_same_cycle", frame_count, 8'd0);
    frame_start = 1'b1;
    tick();
    check("first_swap_count", frame_count, 8'd1);
    read_px("px_5_7", 5, 7, 3'd5);
    read_px("px_corner", H - 1, V - 1, 3'd2);
    read_px("px_write_on_done", 0, 0, 3'd4);
    read_px("px_alias_x_oob", 0, 1, CC);
    read_px("px_untouched", 1, 0, CC);
    read_px("px_drawx_400", 400, 0, 3'd0);

    // Second frame becomes visible only after the second swap.
    wait_ack(1'b1, cyc, clr);
    set_write(1, 1, 3'd7);
    read_px("px_1_1_during_render", 1, 1, CC);
    read_px("px_5_7_during_render", 5, 7, 3'd5);
    tick(); render_done = 1'b1;
    tick(); frame_start = 1'b1;
    read_px("px_1_1_after_swap", 1, 1, 3'd7);
    read_px("px_5_7_after_swap", 5, 7, CC);
    check("second_swap_count", frame_count, 8'd2);
    rand_draw = 1'b1;

    // Random frames up to 256 swaps in total.
    for (int f = 2; f < 256; f++) begin
      wait_ack(1'b1, cyc, clr);
      render_frame(int'($urandom_range(8, 24)), ($urandom_range(0, 3) == 0));
    end
    tick();
    check("count_wrap", frame_count, 8'd0);

    // One more swap, then reset in the middle of the clear.
    wait_ack(1'b1, cyc, clr);
    render_frame(10, 1'b0);
    repeat (NPIX / 2) tick();
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("rst_clearing", 8'(clearing), 8'd0);
    check("rst_ack", 8'(render_ack), 8'd0);
    check("rst_count", frame_count, 8'd0);
    check("rst_pixel", 8'(pixel_color), 8'd0);
    repeat (3) tick();
    Reset = 1'b1;
    wait_ack(1'b0, cyc, clr);
    check("rerun_ack_latency", 8'(cyc), 8'(NPIX + 1));
    check("rerun_clear_len", 8'(clr), 8'(NPIX));
    rand_draw = 1'b0;
    read_px("px_no_front_after_reset", 5, 7, 3'd0);
    tick();
    finish_run();
  end

endmodule
